// File: rtl/instruction_memory_loader_pkg.sv
// Shared definitions for the instruction memory loader: state encoding,
// default program parameters and a small sizing helper.
package instruction_memory_loader_pkg;

    localparam int BITS_FOR_STATE_COUNTER_LOADER = 3;
    localparam int BYTE_WIDTH                    = 8;
    localparam int BYTES_PER_WORD                = 4;

    localparam int          DEFAULT_MEM_WORDS = 64;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [BITS_FOR_STATE_COUNTER_LOADER-1:0] {
        ST_IDLE    = 3'd0,
        ST_RECEIVE = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } loader_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int count_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instruction_memory_loader_packer.sv
// Byte-to-word packer: shifts bytes in MSB-first and flags the transfer that
// completes a word.
module byte_word_packer
    import instruction_memory_loader_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [BYTE_WIDTH-1:0] data_in,
    output logic [WORD_SIZE-1:0]  word,
    output logic                  word_full
);

    logic [1:0] count;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the shift.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
            word  <= '0;
        end else if (push) begin
            count <= count + 2'd1;
            word  <= {word[WORD_SIZE-BYTE_WIDTH-1:0], data_in};
        end
    end

    assign word_full = push && (count == 2'd3);

endmodule

// File: rtl/instruction_memory_loader.sv
// Instruction memory write side: receives the program byte stream, packs it
// into words and writes them from address 0 until HALT or memory full.
module instruction_memory_loader
    import instruction_memory_loader_pkg::*;
#(
    parameter int                   PC_SIZE   = 32,
    parameter int                   WORD_SIZE = 32,
    parameter int                   MEM_WORDS = DEFAULT_MEM_WORDS,
    parameter logic [WORD_SIZE-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_byte_valid,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    output logic                  o_byte_ready,
    output logic                  o_mem_wr_en,
    output logic [PC_SIZE-1:0]    o_mem_wr_addr,
    output logic [WORD_SIZE-1:0]  o_mem_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow
);

    localparam int                 WC_BITS   = count_bits(MEM_WORDS);
    localparam logic [WC_BITS-1:0] LAST_WORD = WC_BITS'(MEM_WORDS - 1);

    loader_state_e        state;
    loader_state_e        next_state;
    logic [PC_SIZE-1:0]   addr;
    logic [WC_BITS-1:0]   word_count;
    logic [WORD_SIZE-1:0] packed_word;
    logic                 push;
    logic                 word_full;
    logic                 clear_counters;
    logic                 advance;

    assign push = i_byte_valid && o_byte_ready;

    byte_word_packer #(
        .WORD_SIZE (WORD_SIZE)
    ) u_packer (
        .clk       (i_clk),
        .reset     (i_reset),
        .clear     (clear_counters),
        .push      (push),
        .data_in   (i_byte),
        .word      (packed_word),
        .word_full (word_full)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state     = state;
        clear_counters = 1'b0;
        advance        = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    next_state     = ST_RECEIVE;
                    clear_counters = 1'b1;
                end
            end
            ST_RECEIVE: begin
                if (word_full) begin
                    next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // HALT takes priority so a HALT in the last slot still completes.
                if (packed_word == HALT_WORD) begin
                    next_state = ST_DONE;
                end else if (word_count == LAST_WORD) begin
                    next_state = ST_ERROR;
                end else begin
                    next_state = ST_RECEIVE;
                    advance    = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || clear_counters) begin
            addr       <= '0;
            word_count <= '0;
        end else if (advance) begin
            addr       <= addr + PC_SIZE'(BYTES_PER_WORD);
            word_count <= word_count + WC_BITS'(1);
        end
    end

    // Outputs depend on state alone, keeping the ready/transfer path loop-free.
    assign o_byte_ready  = (state == ST_RECEIVE);
    assign o_mem_wr_en   = (state == ST_WRITE);
    assign o_busy        = (state == ST_RECEIVE) || (state == ST_WRITE);
    assign o_done        = (state == ST_DONE);
    assign o_overflow    = (state == ST_ERROR);
    assign o_mem_wr_addr = addr;
    assign o_mem_wr_data = packed_word;

endmodule
